// File: rtl/chs_zone_ctrl.sv
// chs_zone_ctrl: per-zone cool/heat hysteresis FSM with glitch-free fan PWM; define CHS_RAMP_EN for a 1-LSB-per-period duty ramp
module chs_zone_ctrl #(
  parameter int ZONES   = 2,
  parameter int PWM_W   = 8,
  parameter int TEMP_W  = 8,
  parameter int HYST    = 2,
  parameter int MIN_OFF = 16
) (
  input  logic                    clk,
  input  logic                    arst,
  input  logic [ZONES-1:0]        zone_en,
  input  logic [ZONES*TEMP_W-1:0] temp,
  input  logic [TEMP_W-1:0]       t_low,
  input  logic [TEMP_W-1:0]       t_high,
  input  logic [ZONES*PWM_W-1:0]  speed,
  output logic [2*ZONES-1:0]      chs_mode,
  output logic [4*ZONES-1:0]      chs_power,
  output logic [ZONES-1:0]        pwm_data,
  output logic                    cfg_err
);
  localparam logic [1:0] S_OFF = 2'b00, S_COOL = 2'b01, S_HEAT = 2'b10;
  localparam int DW = $clog2(MIN_OFF + 2);
  localparam logic [TEMP_W:0] HY = (TEMP_W+1)'(HYST);
  localparam logic [TEMP_W:0] T_MAX = {1'b0, {TEMP_W{1'b1}}};
  logic [PWM_W-1:0] cnt;
  logic wrap;
  logic [TEMP_W:0] thr_c, thr_h, sum_h;
  assign wrap  = &cnt;
  assign thr_c = ({1'b0, t_high} >= HY) ? {1'b0, t_high} - HY : '0;
  assign sum_h = {1'b0, t_low} + HY;
  assign thr_h = (sum_h > T_MAX) ? T_MAX : sum_h;
  // signed difference in TEMP_W+1 bits, clamped to the 1..15 power range
  function automatic logic [3:0] sat4(input logic [TEMP_W:0] d);
    return (d[TEMP_W] || d == '0) ? 4'd1 : (d > (TEMP_W+1)'(15)) ? 4'd15 : d[3:0];
  endfunction
  always_ff @(posedge clk)
    if (arst) begin
      cnt     <= '0;
      cfg_err <= 1'b0;
    end else begin
      cnt     <= cnt + 1'b1;
      cfg_err <= t_low >= t_high;
    end
  for (genvar g = 0; g < ZONES; g++) begin : g_zone
    logic [TEMP_W-1:0] t;
    logic [1:0]        st, nst;
    logic [DW-1:0]     dwell;
    logic [PWM_W-1:0]  duty, tgt;
    logic [TEMP_W:0]   dc, dh;
    logic [3:0]        pw, pw_n;
    assign t    = temp[g*TEMP_W +: TEMP_W];
    assign tgt  = (st == S_OFF) ? '0 : speed[g*PWM_W +: PWM_W];
    assign dc   = {1'b0, t} - {1'b0, t_high};
    assign dh   = {1'b0, t_low} - {1'b0, t};
    assign nst  = (!zone_en[g] || cfg_err) ? S_OFF :
                  (st == S_COOL) ? (({1'b0, t} <= thr_c) ? S_OFF : S_COOL) :
                  (st == S_HEAT) ? (({1'b0, t} >= thr_h) ? S_OFF : S_HEAT) :
                  (dwell != '0)  ? S_OFF :
                  (t > t_high)   ? S_COOL :
                  (t < t_low)    ? S_HEAT : S_OFF;
    assign pw_n = (nst == S_COOL) ? sat4(dc) : (nst == S_HEAT) ? sat4(dh) : 4'd0;
    always_ff @(posedge clk)
      if (arst) begin
        st    <= S_OFF;
        dwell <= '0;
        duty  <= '0;
        pw    <= '0;
      end else begin
        st    <= nst;
        pw    <= pw_n;
        dwell <= (nst == S_OFF && st != S_OFF) ? DW'(MIN_OFF) : (dwell != '0) ? dwell - 1'b1 : dwell;
`ifdef CHS_RAMP_EN
        if (wrap) duty <= (tgt > duty) ? duty + 1'b1 : tgt;
`else
        if (wrap) duty <= tgt;
`endif
      end
    assign chs_mode[2*g +: 2]  = st;
    assign chs_power[4*g +: 4] = pw;
    assign pwm_data[g]         = cnt < duty;
  end
endmodule

// File: tb/tb_chs_zone_ctrl.sv
// tb_chs_zone_ctrl: directed stimulus with a cycle-tagged expectation queue drained by an independent monitor
module tb_chs_zone_ctrl;
  localparam bit RAMP =
`ifdef CHS_RAMP_EN
    1'b1;
`else
    1'b0;
`endif
  typedef struct {
    int    cyc;
    int    kind;
    int    z;
    int    val;
    string nm;
  } exp_t;
  logic        clk, arst;
  logic [1:0]  zone_en;
  logic [15:0] temp;
  logic [7:0]  t_low, t_high;
  logic [15:0] speed;
  logic [3:0]  chs_mode;
  logic [7:0]  chs_power;
  logic [1:0]  pwm_data;
  logic        cfg_err;
  exp_t q[$];
  int cyc = 0, p0 = 0, n_chk = 0, n_fail = 0;
  int acc[2];
  chs_zone_ctrl dut (
    .clk(clk), .arst(arst), .zone_en(zone_en), .temp(temp), .t_low(t_low),
    .t_high(t_high), .speed(speed), .chs_mode(chs_mode), .chs_power(chs_power),
    .pwm_data(pwm_data), .cfg_err(cfg_err)
  );
  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  // kinds: 0 mode, 1 power, 2 pwm, 3 cfg_err, 4 pwm-high count of zone z, 5 clear that count
  always @(negedge clk) begin
    int i, act;
    i = 0;
    while (i < q.size()) begin
      if (q[i].cyc < cyc) begin
        n_chk++;
        n_fail++;
        $display("FAIL %s: overdue at cycle %0d, was due %0d", q[i].nm, cyc, q[i].cyc);
        q.delete(i);
      end else if (q[i].cyc == cyc) begin
        if (q[i].kind == 5) acc[q[i].z] = 0;
        else begin
          act = (q[i].kind == 0) ? int'(chs_mode) : (q[i].kind == 1) ? int'(chs_power) :
                (q[i].kind == 2) ? int'(pwm_data) : (q[i].kind == 3) ? int'(cfg_err) : acc[q[i].z];
          n_chk++;
          if (act != q[i].val) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", q[i].nm, act, q[i].val, cyc);
          end
        end
        q.delete(i);
      end else i++;
    end
    for (int z = 0; z < 2; z++) if (pwm_data[z]) acc[z]++;
  end
  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask
  task automatic chk(input string nm, input int kind, input int z, input int val, input int d);
    q.push_back('{cyc + d, kind, z, val, nm});
  endtask
  task automatic window(input string nm, input int z, input int val);
    chk("clr", 5, z, 0, 0);
    chk(nm, 4, z, val, 256);
  endtask
  task automatic wait_cnt(input int k);
    for (int i = 0; i < 256 && ((cyc - p0) % 256) != k; i++) tick(1);
  endtask
  initial begin
    arst = 1'b1; zone_en = 2'b00; temp = '0; t_low = 8'd20; t_high = 8'd25; speed = '0;
    tick(3);
    chk("rst_mode", 0, 0, 0, 0);
    chk("rst_power", 1, 0, 0, 0);
    chk("rst_pwm", 2, 0, 0, 0);
    chk("rst_cfg", 3, 0, 0, 0);
    arst = 1'b0; p0 = cyc; zone_en = 2'b11; temp = {8'd22, 8'd22};
    tick(2);
    chk("idle_mode", 0, 0, 0, 0);
    chk("idle_power", 1, 0, 0, 0);
    chk("idle_pwm", 2, 0, 0, 0);
    chk("idle_cfg", 3, 0, 0, 0);
    temp[7:0] = 8'd30; speed[7:0] = 8'd128;
    tick(1);
    chk("cool_mode", 0, 0, 4'b0001, 0);
    chk("cool_power", 1, 0, 8'h05, 0);
    wait_cnt(0);
    chk("pwm_start", 2, 0, 2'b01, 0);
    chk("pwm_127", 2, 0, RAMP ? 0 : 1, 127);
    chk("pwm_128", 2, 0, 0, 128);
    window("cool_duty", 0, RAMP ? 1 : 128);
    tick(256);
    temp[7:0] = 8'd24;
    tick(1);
    chk("hyst_hold_mode", 0, 0, 4'b0001, 0);
    chk("hyst_hold_power", 1, 0, 8'h01, 0);
    temp[7:0] = 8'd23;
    tick(1);
    chk("hyst_off_mode", 0, 0, 0, 0);
    chk("hyst_off_power", 1, 0, 0, 0);
    temp[7:0] = 8'd10;
    tick(16);
    chk("dwell_block", 0, 0, 0, 0);
    tick(1);
    chk("heat_mode", 0, 0, 4'b0010, 0);
    chk("heat_power", 1, 0, 8'h0A, 0);
    temp[15:8] = 8'd5; speed[15:8] = 8'd255;
    tick(1);
    chk("heat1_mode", 0, 0, 4'b1010, 0);
    chk("heat1_power", 1, 0, 8'hFA, 0);
    wait_cnt(0);
    window("ramp_p1", 1, RAMP ? 1 : 255);
    tick(256);
    window("ramp_p2", 1, RAMP ? 2 : 255);
    tick(256);
    speed[15:8] = 8'd0;
    window("duty_hold", 1, RAMP ? 3 : 255);
    tick(256);
    window("duty_zero", 1, 0);
    tick(256);
    t_low = 8'd30;
    tick(1);
    chk("cfg_set", 3, 0, 1, 0);
    chk("cfg_mode_lag", 0, 0, 4'b1010, 0);
    chk("cfg_power_sat", 1, 0, 8'hFF, 0);
    tick(1);
    chk("cfg_off_mode", 0, 0, 0, 0);
    chk("cfg_off_power", 1, 0, 0, 0);
    chk("cfg_pwm_hold", 2, 0, 2'b01, 0);
    wait_cnt(0);
    chk("cfg_pwm_low", 2, 0, 0, 0);
    window("cfg_duty0", 0, 0);
    window("cfg_duty1", 1, 0);
    tick(256);
    t_low = 8'd20; speed[7:0] = 8'd200;
    tick(1);
    chk("cfg_clear", 3, 0, 0, 0);
    tick(1);
    chk("rearm_mode", 0, 0, 4'b1010, 0);
    chk("rearm_power", 1, 0, 8'hFA, 0);
    wait_cnt(0);
    wait_cnt(100);
    chk("pre_rst_pwm", 2, 0, RAMP ? 0 : 1, 0);
    arst = 1'b1;
    tick(1);
    chk("mid_rst_pwm", 2, 0, 0, 0);
    chk("mid_rst_mode", 0, 0, 0, 0);
    chk("mid_rst_power", 1, 0, 0, 0);
    chk("mid_rst_cfg", 3, 0, 0, 0);
    arst = 1'b0; p0 = cyc;
    window("post_rst_p0", 0, 0);
    tick(256);
    window("post_rst_p1", 0, RAMP ? 1 : 200);
    tick(256);
    for (int i = 0; i < 600 && q.size() != 0; i++) tick(1);
    if (q.size() != 0) begin
      n_chk++;
      n_fail++;
      $display("FAIL drain: %0d pending, expected 0", q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
